// File: rtl/sort_share_arbiter.sv
// rtl/sort_share_arbiter.sv - two-channel frame collector time-sharing one external 4-input sorter
//
// Purpose: buffers a 4-nibble signed frame and a 2-bit mode from each of two
// serial requesters, grants the shared combinational sorter round-robin, then
// streams four 6-bit signed results derived from the sorted operands.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   reqN_valid/number/mode       channel N beat strobe, signed beat, mode (beat 0)
//   reqN_busy                    channel N holds a complete frame; beats ignored
//   srt_in0..3                   operands to the shared sorter (0 outside LOAD)
//   srt_out0..3                  sorter outputs, ascending, combinational
//   out_valid/out_id/out_result  result strobe, owning channel, signed result
module sort_share_arbiter #(
  parameter int NUM_BEATS = 4,
  parameter int RES_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_number,
  input  logic [1:0]       req0_mode,
  output logic             req0_busy,
  input  logic             req1_valid,
  input  logic [3:0]       req1_number,
  input  logic [1:0]       req1_mode,
  output logic             req1_busy,
  output logic [3:0]       srt_in0,
  output logic [3:0]       srt_in1,
  output logic [3:0]       srt_in2,
  output logic [3:0]       srt_in3,
  input  logic [3:0]       srt_out0,
  input  logic [3:0]       srt_out1,
  input  logic [3:0]       srt_out2,
  input  logic [3:0]       srt_out3,
  output logic             out_valid,
  output logic             out_id,
  output logic [RES_W-1:0] out_result
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_t;
  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  state_t r_state, w_state_nxt;

  logic [NUM_BEATS-1:0][3:0] r_buf0, r_buf1, r_s, w_sel;
  logic [1:0]       r_cnt0, r_cnt1, r_mode0, r_mode1, r_gmode, r_ocnt;
  logic             r_busy0, r_busy1, r_rr, r_grant;
  logic             r_out_valid, r_out_id;
  logic [RES_W-1:0] r_out_result;
  logic             w_any_busy, w_arb, w_eval, w_load;

  // Operands are sign-extended to RES_W first; two's-complement add/sub on
  // equal-width vectors then yields the signed result directly.
  function automatic logic [RES_W-1:0] f_result(input logic [1:0] mode, input logic [1:0] idx,
                                                input logic [NUM_BEATS-1:0][3:0] s);
    logic [RES_W-1:0] e0, e1, e2, e3, res;
    e0 = {{(RES_W-4){s[0][3]}}, s[0]};
    e1 = {{(RES_W-4){s[1][3]}}, s[1]};
    e2 = {{(RES_W-4){s[2][3]}}, s[2]};
    e3 = {{(RES_W-4){s[3][3]}}, s[3]};
    res = '0;
    case (mode)
      2'd0: case (idx) 2'd0: res = e0; 2'd1: res = e1; 2'd2: res = e2; default: res = e3; endcase
      2'd1: case (idx) 2'd0: res = e3; 2'd1: res = e2; 2'd2: res = e1; default: res = e0; endcase
      2'd2: case (idx)
        2'd0: res = e0 + e1; 2'd1: res = e1 + e2; 2'd2: res = e2 + e3; default: res = e3 + e0;
      endcase
      default: case (idx)
        2'd0: res = e0 - e1; 2'd1: res = e1 - e2; 2'd2: res = e3 - e2; default: res = e3 - e0;
      endcase
    endcase
    return res;
  endfunction

  assign w_load     = (r_state == S_LOAD);
  assign w_any_busy = r_busy0 | r_busy1;
  // Tie goes to the rr pointer; otherwise whichever channel is busy.
  assign w_arb      = (r_busy0 && r_busy1) ? r_rr : r_busy1;
  assign w_eval     = (r_state == S_IDLE) || ((r_state == S_OUT) && (r_ocnt == LAST_BEAT));

  // Collectors: busy clears on the LOAD edge, so the owner may refill during OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0; r_cnt0 <= '0; r_mode0 <= '0; r_busy0 <= 1'b0;
    end else if (r_busy0) begin
      if (w_load && !r_grant) r_busy0 <= 1'b0;
    end else if (req0_valid) begin
      r_buf0[r_cnt0] <= req0_number;
      if (r_cnt0 == 2'd0) r_mode0 <= req0_mode;
      if (r_cnt0 == LAST_BEAT) begin
        r_busy0 <= 1'b1;
        r_cnt0  <= '0;
      end else begin
        r_cnt0 <= r_cnt0 + 2'd1;
      end
    end else begin
      r_cnt0 <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf1 <= '0; r_cnt1 <= '0; r_mode1 <= '0; r_busy1 <= 1'b0;
    end else if (r_busy1) begin
      if (w_load && r_grant) r_busy1 <= 1'b0;
    end else if (req1_valid) begin
      r_buf1[r_cnt1] <= req1_number;
      if (r_cnt1 == 2'd0) r_mode1 <= req1_mode;
      if (r_cnt1 == LAST_BEAT) begin
        r_busy1 <= 1'b1;
        r_cnt1  <= '0;
      end else begin
        r_cnt1 <= r_cnt1 + 2'd1;
      end
    end else begin
      r_cnt1 <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_busy) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_OUT;
      S_OUT:   if (r_ocnt == LAST_BEAT) w_state_nxt = w_any_busy ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr         <= 1'b0;
      r_grant      <= 1'b0;
      r_gmode      <= '0;
      r_ocnt       <= '0;
      r_s          <= '0;
      r_out_valid  <= 1'b0;
      r_out_id     <= 1'b0;
      r_out_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_eval && w_any_busy) begin
        r_grant <= w_arb;
        r_rr    <= ~w_arb;
        r_gmode <= w_arb ? r_mode1 : r_mode0;
      end
      if (w_load) begin
        // First result comes straight from the sorter so it is valid on the OUT entry edge.
        r_s          <= {srt_out3, srt_out2, srt_out1, srt_out0};
        r_ocnt       <= '0;
        r_out_valid  <= 1'b1;
        r_out_id     <= r_grant;
        r_out_result <= f_result(r_gmode, 2'd0, {srt_out3, srt_out2, srt_out1, srt_out0});
      end else if (r_state == S_OUT) begin
        if (r_ocnt == LAST_BEAT) begin
          r_out_valid <= 1'b0;
        end else begin
          r_ocnt       <= r_ocnt + 2'd1;
          r_out_result <= f_result(r_gmode, r_ocnt + 2'd1, r_s);
        end
      end
    end
  end

  always_comb begin
    w_sel = r_grant ? r_buf1 : r_buf0;
    {srt_in3, srt_in2, srt_in1, srt_in0} = '0;
    if (w_load) {srt_in3, srt_in2, srt_in1, srt_in0} = w_sel;
  end

  assign req0_busy  = r_busy0;
  assign req1_busy  = r_busy1;
  assign out_valid  = r_out_valid;
  assign out_id     = r_out_id;
  assign out_result = r_out_result;

endmodule
